qpsk_demod: RTL and testbench

Coherent QPSK demodulator; the receive-side counterpart of the team's QPSK modulator. It correlates the received 8-bit signed QPSK samples against the same local sine/cos carrier references over one symbol period. It slices the signs into a dibit and re-serialises the dibit into the original bit stream, low bit first. It sits after the channel/ADC path and before the bit sink, and shares the carrier ROM outputs with the modulator.

---
 rtl/qpsk_demod.sv | 136 +++++++++++++
 tb/tb_qpsk_demod.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_demod.sv
// Coherent QPSK demodulator: correlates rx samples against the local cos/sine
// carriers over one symbol, slices the signs to a dibit and serialises it low bit first.
module qpsk_demod #(
    parameter  int unsigned SPS   = 16,
    localparam int unsigned ACC_W = 16 + $clog2(SPS) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic                    sym_start,
    input  logic signed [7:0]       rx_seq,
    input  logic signed [7:0]       sine,
    input  logic signed [7:0]       cos,
    output logic [1:0]              data,
    output logic                    data_valid,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic signed [ACC_W-1:0] i_metric,
    output logic signed [ACC_W-1:0] q_metric
);

    localparam int unsigned CNT_W  = $clog2(SPS);
    localparam int unsigned PROD_W = 16;

    logic signed [PROD_W-1:0] pi_c, pq_c;
    logic signed [ACC_W-1:0]  pi_ext_c, pq_ext_c, si_c, sq_c;
    logic                     si_pos_c, sq_pos_c, last_c;

    logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               data_q, data_d;
    logic                     dv_q, dv_d;
    logic                     bit_out_q, bit_out_d;
    logic                     bv_q, bv_d;
    logic                     pend_q, pend_d;
    logic                     pend_bit_q, pend_bit_d;
    logic signed [ACC_W-1:0]  i_met_q, i_met_d, q_met_q, q_met_d;

    // Full-precision products; the widened accumulator cannot overflow over SPS samples.
    assign pi_c     = PROD_W'(rx_seq) * PROD_W'(cos);
    assign pq_c     = PROD_W'(rx_seq) * PROD_W'(sine);
    assign pi_ext_c = ACC_W'(pi_c);
    assign pq_ext_c = ACC_W'(pq_c);
    assign si_c     = acc_i_q + pi_ext_c;
    assign sq_c     = acc_q_q + pq_ext_c;
    // Strictly positive decides 1; an exact zero decides 0.
    assign si_pos_c = (si_c != '0) && !si_c[ACC_W-1];
    assign sq_pos_c = (sq_c != '0) && !sq_c[ACC_W-1];
    assign last_c   = sample_en && (cnt_q == CNT_W'(SPS - 1));

    always_comb begin
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        dv_d       = 1'b0;
        i_met_d    = i_met_q;
        q_met_d    = q_met_q;
        bit_out_d  = bit_out_q;
        bv_d       = 1'b0;
        pend_d     = 1'b0;
        pend_bit_d = pend_bit_q;

        // Second half of the serializer; never collides with a decision since SPS >= 2.
        if (pend_q) begin
            bit_out_d = pend_bit_q;
            bv_d      = 1'b1;
        end

        if (sym_start) begin
            if (sample_en) begin
                acc_i_d = pi_ext_c;
                acc_q_d = pq_ext_c;
                cnt_d   = CNT_W'(1);
            end else begin
                acc_i_d = '0;
                acc_q_d = '0;
                cnt_d   = '0;
            end
        end else if (sample_en) begin
            if (last_c) begin
                data_d     = {sq_pos_c, si_pos_c};
                dv_d       = 1'b1;
                i_met_d    = si_c;
                q_met_d    = sq_c;
                bit_out_d  = si_pos_c;
                bv_d       = 1'b1;
                pend_d     = 1'b1;
                pend_bit_d = sq_pos_c;
                acc_i_d    = '0;
                acc_q_d    = '0;
                cnt_d      = '0;
            end else begin
                acc_i_d = si_c;
                acc_q_d = sq_c;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            i_met_q    <= '0;
            q_met_q    <= '0;
            bit_out_q  <= 1'b0;
            bv_q       <= 1'b0;
            pend_q     <= 1'b0;
            pend_bit_q <= 1'b0;
        end else begin
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            i_met_q    <= i_met_d;
            q_met_q    <= q_met_d;
            bit_out_q  <= bit_out_d;
            bv_q       <= bv_d;
            pend_q     <= pend_d;
            pend_bit_q <= pend_bit_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign bit_out    = bit_out_q;
    assign bit_valid  = bv_q;
    assign i_metric   = i_met_q;
    assign q_metric   = q_met_q;

endmodule

// File: tb/tb_qpsk_demod.sv
// Bench for qpsk_demod: table-driven SPS=4 symbols and corner sequences, plus an
// SPS=16 loopback from a behavioural modulator, all checked through scoreboard queues.
module tb_qpsk_demod;

    localparam int unsigned SPS4  = 4;
    localparam int unsigned SPS16 = 16;
    localparam int unsigned AW4   = 16 + $clog2(SPS4) + 1;
    localparam int unsigned AW16  = 16 + $clog2(SPS16) + 1;
    localparam real         PI    = 3.14159265358979;

    typedef struct {
        logic [3:0][7:0] rx;
        logic [1:0]      d;
        int              im;
        int              qm;
    } vec_t;

    typedef struct {
        logic [1:0] d;
        int         im;
        int         qm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                   en4, ss4, en16, ss16;
    logic signed [7:0]      rx4, sin4, cos4, rx16, sin16, cos16;
    logic [1:0]             d4, d16;
    logic                   dv4, bo4, bv4, dv16, bo16, bv16;
    logic signed [AW4-1:0]  im4, qm4;
    logic signed [AW16-1:0] im16, qm16;

    qpsk_demod #(.SPS(SPS4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sample_en(en4), .sym_start(ss4),
        .rx_seq(rx4), .sine(sin4), .cos(cos4),
        .data(d4), .data_valid(dv4), .bit_out(bo4), .bit_valid(bv4),
        .i_metric(im4), .q_metric(qm4)
    );

    qpsk_demod #(.SPS(SPS16)) dut16 (
        .clk(clk), .rst_n(rst_n), .sample_en(en16), .sym_start(ss16),
        .rx_seq(rx16), .sine(sin16), .cos(cos16),
        .data(d16), .data_valid(dv16), .bit_out(bo16), .bit_valid(bv16),
        .i_metric(im16), .q_metric(qm16)
    );

    int   c4[4] = '{100, 0, -100, 0};
    int   s4[4] = '{0, 100, 0, -100};
    int   c16[16];
    int   s16[16];

    int   n_tot = 0;
    int   n_pass = 0;
    exp_t q4[$];
    exp_t q16[$];
    logic b4[$];
    logic b16[$];
    int   pushed4 = 0, pushed16 = 0, dvcnt4 = 0, dvcnt16 = 0;
    exp_t e4, e16;
    logic eb4, eb16;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Scoreboard pop for the SPS=4 instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dv4) begin
                dvcnt4++;
                if (q4.size() == 0) begin
                    n_tot++;
                    $display("FAIL dv4_unexpected: got data_valid pulse, expected none");
                end else begin
                    e4 = q4.pop_front();
                    chk("data4", int'(d4), int'(e4.d));
                    chk("i_metric4", int'(im4), e4.im);
                    chk("q_metric4", int'(qm4), e4.qm);
                end
            end
            if (bv4) begin
                if (b4.size() == 0) begin
                    n_tot++;
                    $display("FAIL bv4_unexpected: got bit_valid pulse, expected none");
                end else begin
                    eb4 = b4.pop_front();
                    chk("bit4", int'(bo4), int'(eb4));
                end
            end
        end
    end

    // Scoreboard pop for the SPS=16 loopback instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dv16) begin
                dvcnt16++;
                if (q16.size() == 0) begin
                    n_tot++;
                    $display("FAIL dv16_unexpected: got data_valid pulse, expected none");
                end else begin
                    e16 = q16.pop_front();
                    chk("data16", int'(d16), int'(e16.d));
                    chk("i_metric16", int'(im16), e16.im);
                    chk("q_metric16", int'(qm16), e16.qm);
                end
            end
            if (bv16) begin
                if (b16.size() == 0) begin
                    n_tot++;
                    $display("FAIL bv16_unexpected: got bit_valid pulse, expected none");
                end else begin
                    eb16 = b16.pop_front();
                    chk("bit16", int'(bo16), int'(eb16));
                end
            end
        end
    end

    function automatic vec_t mk(input int r0, input int r1, input int r2, input int r3,
                                input logic [1:0] d, input int im, input int qm);
        vec_t v;
        v.rx[0] = 8'(r0);
        v.rx[1] = 8'(r1);
        v.rx[2] = 8'(r2);
        v.rx[3] = 8'(r3);
        v.d     = d;
        v.im    = im;
        v.qm    = qm;
        return v;
    endfunction

    task automatic step4(input logic en, input logic ss, input logic signed [7:0] rx, input int k);
        en4  = en;
        ss4  = ss;
        rx4  = rx;
        cos4 = 8'(c4[k]);
        sin4 = 8'(s4[k]);
        @(posedge clk);
        #1;
    endtask

    task automatic idle4(input int n);
        repeat (n) step4(1'b0, 1'b0, 8'sd0, 0);
    endtask

    task automatic send4(input vec_t v, input logic ss_first, input logic gaps);
        exp_t e;
        e.d  = v.d;
        e.im = v.im;
        e.qm = v.qm;
        q4.push_back(e);
        b4.push_back(v.d[0]);
        b4.push_back(v.d[1]);
        pushed4++;
        for (int k = 0; k < 4; k++) begin
            if (gaps && k > 0) step4(1'b0, 1'b0, 8'sd77, (k + 1) % 4);
            step4(1'b1, ss_first && (k == 0), v.rx[k], k);
        end
        chk("latency4", int'(dv4), 1);
    endtask

    task automatic step16(input logic en, input logic ss, input logic signed [7:0] rx, input int k);
        en16  = en;
        ss16  = ss;
        rx16  = rx;
        cos16 = 8'(c16[k]);
        sin16 = 8'(s16[k]);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, int'(d4), 0);
        chk({tag, "_data_valid"}, int'(dv4), 0);
        chk({tag, "_bit_out"}, int'(bo4), 0);
        chk({tag, "_bit_valid"}, int'(bv4), 0);
        chk({tag, "_i_metric"}, int'(im4), 0);
        chk({tag, "_q_metric"}, int'(qm4), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[5];
        int   rx[16];
        int   si, sq;
        logic b0, b1;
        exp_t e;

        tbl[0] = mk( 50,  50, -50, -50, 2'b11,  10000,  10000);
        tbl[1] = mk( 50, -50, -50,  50, 2'b01,  10000, -10000);
        tbl[2] = mk(-50, -50,  50,  50, 2'b00, -10000, -10000);
        tbl[3] = mk(-50,  50,  50, -50, 2'b10, -10000,  10000);
        tbl[4] = mk(  0,   0,   0,   0, 2'b00,      0,      0);

        for (int k = 0; k < 16; k++) begin
            c16[k] = int'(100.0 * $cos(2.0 * PI * k / 16.0));
            s16[k] = int'(100.0 * $sin(2.0 * PI * k / 16.0));
        end

        rst_n = 1'b0;
        en4 = 1'b0; ss4 = 1'b0; rx4 = '0; cos4 = '0; sin4 = '0;
        en16 = 1'b0; ss16 = 1'b0; rx16 = '0; cos16 = '0; sin16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle4(2);

        for (int i = 0; i < 5; i++) begin
            send4(tbl[i], 1'b0, 1'b0);
            idle4(4);
            chk("hold_data4", int'(d4), int'(tbl[i].d));
            chk("hold_i_metric4", int'(im4), tbl[i].im);
        end

        // Truncated symbol: restart at sample 2, partial is discarded.
        step4(1'b1, 1'b0, 8'sd60, 0);
        step4(1'b1, 1'b0, 8'sd60, 1);
        send4(tbl[1], 1'b1, 1'b0);
        idle4(4);

        // sym_start without sample_en clears the partial symbol.
        step4(1'b1, 1'b0, -8'sd40, 0);
        step4(1'b1, 1'b0, 8'sd40, 1);
        step4(1'b0, 1'b1, 8'sd0, 0);
        send4(tbl[3], 1'b0, 1'b0);
        idle4(4);

        // sym_start on the last sample wins over the decision.
        step4(1'b1, 1'b0, -8'sd50, 0);
        step4(1'b1, 1'b0, -8'sd50, 1);
        step4(1'b1, 1'b0, 8'sd50, 2);
        send4(tbl[0], 1'b1, 1'b0);
        idle4(4);

        // Gapped sample_en gives the same result as continuous.
        send4(tbl[0], 1'b0, 1'b1);
        idle4(4);

        // Reset mid-symbol, then a fresh symbol from sample 0.
        step4(1'b1, 1'b0, 8'sd50, 0);
        step4(1'b1, 1'b0, 8'sd50, 1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send4(tbl[2], 1'b0, 1'b0);
        idle4(4);

        // SPS=16 loopback of 64 random bits, back-to-back symbols.
        for (int s = 0; s < 32; s++) begin
            b0 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            si = 0;
            sq = 0;
            for (int k = 0; k < 16; k++) begin
                rx[k] = ((b0 ? c16[k] : -c16[k]) + (b1 ? s16[k] : -s16[k])) * 6 / 10;
                si += rx[k] * c16[k];
                sq += rx[k] * s16[k];
            end
            e.d  = {b1, b0};
            e.im = si;
            e.qm = sq;
            q16.push_back(e);
            b16.push_back(b0);
            b16.push_back(b1);
            pushed16++;
            for (int k = 0; k < 16; k++) step16(1'b1, k == 0, 8'(rx[k]), k);
        end
        repeat (6) step16(1'b0, 1'b0, 8'sd0, 0);

        chk("q4_drained", q4.size(), 0);
        chk("b4_drained", b4.size(), 0);
        chk("dv4_count", dvcnt4, pushed4);
        chk("q16_drained", q16.size(), 0);
        chk("b16_drained", b16.size(), 0);
        chk("dv16_count", dvcnt16, pushed16);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
